// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback stage: selects the result, extracts and
// extends load data, drives the register-file write port and counts retired instructions.
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              in_link,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_unsigned,
    input  logic [1:0]        in_byte_offset,
    input  logic [ADDR_W-1:0] in_write_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus8,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_valid,
    output logic              align_err,
    output logic [CNT_W-1:0]  instret
);

    logic              valid_reg;
    logic              reg_write_flag_reg;
    logic              mem_to_reg_reg;
    logic              link_reg;
    logic [1:0]        load_size_reg;
    logic              load_unsigned_reg;
    logic [1:0]        byte_offset_reg;
    logic [ADDR_W-1:0] write_reg_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic [DATA_W-1:0] pc_plus8_reg;
    logic              written_reg;
    logic [CNT_W-1:0]  instret_reg;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] result;
    logic              misaligned;
    logic              align_err_int;
    logic              retire;

    // An entry retires once: either as it leaves, or at the first stalled edge.
    assign retire = valid_reg & ~align_err_int & ~written_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg          <= 1'b0;
            reg_write_flag_reg <= 1'b0;
            mem_to_reg_reg     <= 1'b0;
            link_reg           <= 1'b0;
            load_size_reg      <= 2'b00;
            load_unsigned_reg  <= 1'b0;
            byte_offset_reg    <= 2'b00;
            write_reg_reg      <= '0;
            alu_result_reg     <= '0;
            mem_data_reg       <= '0;
            pc_plus8_reg       <= '0;
            written_reg        <= 1'b0;
            instret_reg        <= '0;
        end else begin
            if (retire) begin
                instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                valid_reg   <= 1'b0;
                written_reg <= 1'b0;
            end else if (!stall) begin
                valid_reg          <= in_valid;
                reg_write_flag_reg <= in_reg_write;
                mem_to_reg_reg     <= in_mem_to_reg;
                link_reg           <= in_link;
                load_size_reg      <= in_load_size;
                load_unsigned_reg  <= in_load_unsigned;
                byte_offset_reg    <= in_byte_offset;
                write_reg_reg      <= in_write_reg;
                alu_result_reg     <= in_alu_result;
                mem_data_reg       <= in_mem_data;
                pc_plus8_reg       <= in_pc_plus8;
                written_reg        <= 1'b0;
            end else if (valid_reg) begin
                written_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        byte_sel = mem_data_reg[7:0];
        case (byte_offset_reg)
            2'd0:    byte_sel = mem_data_reg[7:0];
            2'd1:    byte_sel = mem_data_reg[15:8];
            2'd2:    byte_sel = mem_data_reg[23:16];
            default: byte_sel = mem_data_reg[31:24];
        endcase
        half_sel = byte_offset_reg[1] ? mem_data_reg[31:16] : mem_data_reg[15:0];

        load_data  = mem_data_reg;
        misaligned = 1'b0;
        case (load_size_reg)
            2'b00: begin
                load_data  = mem_data_reg;
                misaligned = (byte_offset_reg != 2'b00);
            end
            2'b01: begin
                load_data  = {{(DATA_W-16){~load_unsigned_reg & half_sel[15]}}, half_sel};
                misaligned = byte_offset_reg[0];
            end
            2'b10: begin
                load_data  = {{(DATA_W-8){~load_unsigned_reg & byte_sel[7]}}, byte_sel};
                misaligned = 1'b0;
            end
            default: begin
                load_data  = mem_data_reg;
                misaligned = 1'b1;
            end
        endcase

        if (link_reg) begin
            result = pc_plus8_reg;
        end else if (mem_to_reg_reg) begin
            result = load_data;
        end else begin
            result = alu_result_reg;
        end
    end

    assign align_err_int = valid_reg & mem_to_reg_reg & misaligned;

    assign align_err  = align_err_int;
    assign wb_valid   = valid_reg;
    assign reg_write  = valid_reg & reg_write_flag_reg & (write_reg_reg != '0)
                        & ~align_err_int & ~written_reg;
    assign write_reg  = valid_reg ? write_reg_reg : '0;
    assign write_data = valid_reg ? result : '0;
    assign instret    = instret_reg;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: each step pushes its expected stage outputs
// to a queue, then pops and compares them after the clock edge.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_link;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [1:0]  in_byte_offset;
    logic [4:0]  in_write_reg;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc_plus8;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        wb_valid;
    logic        align_err;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        ae;
        logic        v;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];

    mem_wb_writeback #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_reg_write     (in_reg_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_link          (in_link),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_byte_offset   (in_byte_offset),
        .in_write_reg     (in_write_reg),
        .in_alu_result    (in_alu_result),
        .in_mem_data      (in_mem_data),
        .in_pc_plus8      (in_pc_plus8),
        .reg_write        (reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .wb_valid         (wb_valid),
        .align_err        (align_err),
        .instret          (instret)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, field, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                              input logic ae, input logic v, input logic [31:0] ir);
        exp_t e;
        e.tag = tag; e.rw = rw; e.wr = wr; e.wd = wd; e.ae = ae; e.v = v; e.ir = ir;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "reg_write",  {31'd0, reg_write},  {31'd0, e.rw});
            cmp(e.tag, "write_reg",  {27'd0, write_reg},  {27'd0, e.wr});
            cmp(e.tag, "write_data", write_data,          e.wd);
            cmp(e.tag, "align_err",  {31'd0, align_err},  {31'd0, e.ae});
            cmp(e.tag, "wb_valid",   {31'd0, wb_valid},   {31'd0, e.v});
            cmp(e.tag, "instret",    instret,             e.ir);
            $display("step %-10s rw=%0b wr=%0d wd=%08h ae=%0b v=%0b ir=%0d",
                     e.tag, reg_write, write_reg, write_data, align_err, wb_valid, instret);
        end
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic [1:0] sz, input logic uns, input logic [1:0] off,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc8);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_link = lnk;
        in_load_size = sz; in_load_unsigned = uns; in_byte_offset = off;
        in_write_reg = rd; in_alu_result = alu; in_mem_data = mem; in_pc_plus8 = pc8;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
        check();
        rst = 1'b0;

        // Capture then stall, then reset asynchronously while the entry is held.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd9, 32'hAAAA_5555, 32'h0, 32'h0);
        expect_out("cap9", 1'b1, 5'd9, 32'hAAAA_5555, 1'b0, 1'b1, 32'd0);
        tick_check();
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd3, 32'h3333_3333, 32'h0, 32'h0);
        expect_out("hold9", 1'b0, 5'd9, 32'hAAAA_5555, 1'b0, 1'b1, 32'd1);
        tick_check();
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
        check();
        #2 rst = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick_check();

        // ALU write, then a bubble to show the write lasts one cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
        expect_out("alu5", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b1, 32'd0);
        tick_check();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("bubble1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd1);
        tick_check();

        // Loads from mem_data = 0x80FF_1234.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'd3, 5'd10, 32'h0, 32'h80FF_1234, 32'h0);
        expect_out("lb_off3", 1'b1, 5'd10, 32'hFFFF_FF80, 1'b0, 1'b1, 32'd1);
        tick_check();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 2'd3, 5'd11, 32'h0, 32'h80FF_1234, 32'h0);
        expect_out("lbu_off3", 1'b1, 5'd11, 32'h0000_0080, 1'b0, 1'b1, 32'd2);
        tick_check();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'd2, 5'd12, 32'h0, 32'h80FF_1234, 32'h0);
        expect_out("lh_off2", 1'b1, 5'd12, 32'hFFFF_80FF, 1'b0, 1'b1, 32'd3);
        tick_check();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd2, 5'd13, 32'h0, 32'h80FF_1234, 32'h0);
        expect_out("lw_off2", 1'b0, 5'd13, 32'h80FF_1234, 1'b1, 1'b1, 32'd4);
        tick_check();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'd1, 5'd14, 32'h0, 32'h80FF_1234, 32'h0);
        expect_out("lh_off1", 1'b0, 5'd14, 32'h0000_1234, 1'b1, 1'b1, 32'd4);
        tick_check();

        // Write to rd=7 followed by a three-cycle stall.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd7, 32'h0000_0077, 32'h0, 32'h0);
        expect_out("rd7", 1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1, 32'd4);
        tick_check();
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd8, 32'h0000_0088, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("stall%0d", i), 1'b0, 5'd7, 32'h0000_0077, 1'b0, 1'b1, 32'd5);
            tick_check();
        end
        stall = 1'b0;

        // rd=0 retires without writing; flush beats stall.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0);
        expect_out("rd0", 1'b0, 5'd0, 32'h0000_DEAD, 1'b0, 1'b1, 32'd5);
        tick_check();
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd6, 32'h0000_0066, 32'h0, 32'h0);
        expect_out("flush", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd6);
        tick_check();
        stall = 1'b0; flush = 1'b0;

        // jal: link address wins over ALU and load data.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 5'd31, 32'hBAD0_BAD0, 32'h1111_1111, 32'h0040_0010);
        expect_out("jal", 1'b1, 5'd31, 32'h0040_0010, 1'b0, 1'b1, 32'd6);
        tick_check();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("bubble2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd7);
        tick_check();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback stage; the writer side of the CPU register file.
- Captures the MEM-stage result and selects ALU result, load data or link address.
- Performs load byte/halfword extraction and sign/zero extension.
- Drives reg_write/write_reg/write_data into the register file, which commits on the following clk rising edge. Also maintains a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- stall  input  1  hold stage register contents.
- flush  input  1  invalidate instruction entering the stage.
- in_valid  input  1  MEM stage holds a real instruction.
- in_reg_write  input  1  instruction writes a register.
- in_mem_to_reg  input  1  result comes from memory load.
- in_link  input  1  result is in_pc_plus8 (jal/jalr).
- in_load_size  input  2  00 word, 01 half, 10 byte, 11 reserved.
- in_load_unsigned  input  1  zero-extend (lbu/lhu) instead of sign-extend.
- in_byte_offset  input  2  load address bits [1:0].
- in_write_reg  input  ADDR_W  destination register.
- in_alu_result  input  DATA_W  ALU result.
- in_mem_data  input  DATA_W  raw word read from data memory.
- in_pc_plus8  input  DATA_W  link address.
- reg_write  output  1  register file write enable.
- write_reg  output  ADDR_W  register file write address.
- write_data  output  DATA_W  register file write data.
- wb_valid  output  1  stage holds a valid instruction.
- align_err  output  1  misaligned or reserved-size load in stage.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: stage register cleared. wb_valid, reg_write, align_err = 0; write_reg = 0; write_data = 0; instret = 0; written flag = 0. Reset asserted mid-stall discards the held instruction with no write.
- Capture: at a rising edge, flush=1 loads a bubble (valid=0), with priority over stall. Otherwise stall=0 loads all in_* fields. stall=1 holds the register.
- Outputs are combinational from the stage register.
  - An instruction captured at edge N drives the write during cycle N→N+1.
  - The register file commits it at edge N+1, giving one cycle of latency.
- Result select, in priority order: in_link → pc_plus8; else mem_to_reg → extracted load data; else alu_result.
- Load extraction uses little-endian byte lanes: offset k selects bits [8k+7:8k].
  - Byte: any offset; 8 bits extended to 32.
  - Half: offset 0 → [15:0], offset 2 → [31:16]; extended to 32.
  - Word: offset must be 00.
  - Sign or zero extension follows in_load_unsigned.
- align_err = valid & mem_to_reg & (half with offset 1/3, or word with offset ≠ 0, or size 11).
- reg_write = valid & reg_write_flag & (write_reg ≠ 0) & !align_err & !written.
  - Writes to $0 are suppressed but still retire.
  - A misaligned load writes nothing and does not retire.
- Stall handling: the written flag sets at the first edge where valid=1 and stall=1, and clears whenever a new entry is captured or flushed. reg_write and the retire therefore happen exactly once per instruction, even under multi-cycle stall.
- instret increments by 1 at an edge when valid & !align_err & !written. It wraps modulo 2^CNT_W. A flush arriving in the same edge does not cancel the count of the instruction leaving the stage.
- write_reg and write_data are driven from the stage register even when reg_write=0. When valid=0, both are forced to 0.

Test Plan:
- Reset with stall=1 and a valid entry held → all outputs 0 and instret=0 immediately, asynchronously. No write occurs after release.
- ALU write: rd=5, alu=0x12345678 → reg_write=1 for exactly one cycle after capture with write_reg=5 and write_data=0x12345678; instret=1.
- lb, offset 3, mem_data=0x80FF_1234 → write_data=0xFFFF_FF80. The same access as lbu → 0x0000_0080. lh at offset 2 → 0xFFFF_80FF.
- lw at offset 2 → align_err=1, reg_write=0, instret unchanged. lh at offset 1 → same response.
- Valid write to rd=7, then stall held for 3 cycles → reg_write high only in the first cycle; instret increments by exactly 1.
- Write with rd=0 → reg_write=0 and instret increments. Flush with stall=1 → wb_valid=0 next cycle. jal with pc_plus8=0x0040_0010, rd=31 → write_data=0x0040_0010.
